// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (icache/dcache) arbiter onto a single RAM port.
// Latency: one registered arbitration cycle from request to RAM enable; data returns in the ram_ready cycle.
// Backpressure: clients are stalled by iwait/dwait=1 until the RAM completes their access via ram_ready.
//
// Ports
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   iREN, iaddr         icache read request and word address
//   iload, iwait        icache read data (copy of ramload) and completion strobe (0 = done)
//   dREN, dWEN          dcache read / write request (write wins if both set)
//   daddr, dstore       dcache word address and write data
//   dload, dwait        dcache read data (copy of ramload) and completion strobe (0 = done)
//   ramREN, ramWEN      RAM read / write enables
//   ramaddr, ramstore   RAM address and write data
//   ramload, ram_ready  RAM read data and access-complete indication
//
// Arbitration summary
//   The dcache normally wins.  After every dcache completion the grant is parked
//   in DHOLD for HOLD_CYCLES cycles so the second word of a two-word block
//   transfer is not overtaken by the icache.  A saturating streak counter
//   counts dcache completions that happened while the icache was waiting; once
//   it reaches MAX_DSTREAK the icache is granted ahead of the dcache.

`default_nettype none

module mem_arbiter #(
   parameter int HOLD_CYCLES = 2,
   parameter int MAX_DSTREAK = 4
) (
   input  logic        CLK,
   input  logic        RST,

   // icache side
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,

   // dcache side
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,

   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready
);

   // ------------------------------------------------------------------
   // Counter widths and constants
   // ------------------------------------------------------------------
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int SW = $clog2(MAX_DSTREAK + 1);

   localparam logic [HW-1:0] HOLD_ZERO = '0;
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);

   localparam logic [SW-1:0] STREAK_ZERO = '0;
   localparam logic [SW-1:0] STREAK_ONE  = SW'(1);
   localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_DSTREAK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2,
      DHOLD  = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [HW-1:0]   hold_cnt;
   logic [HW-1:0]   hold_cnt_nxt;
   logic [SW-1:0]   streak;
   logic [SW-1:0]   streak_nxt;

   // Request summaries shared by next-state and output logic.
   logic d_req;
   logic i_starved;

   assign d_req     = dREN | dWEN;
   // The icache has been passed over MAX_DSTREAK times and must go next.
   assign i_starved = iREN & (streak == STREAK_MAX);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         hold_cnt <= HOLD_ZERO;
         streak   <= STREAK_ZERO;
      end else begin
         state    <= next_state;
         hold_cnt <= hold_cnt_nxt;
         streak   <= streak_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state   = state;
      hold_cnt_nxt = hold_cnt;
      streak_nxt   = streak;

      case (state)
         IDLE: begin
            if (i_starved) begin
               next_state = IGRANT;
            end else if (d_req) begin
               next_state = DGRANT;
            end else if (iREN) begin
               next_state = IGRANT;
            end
         end

         DGRANT: begin
            // A dropped request abandons the access even if the RAM happens
            // to signal ready in the same cycle: the enables are already low.
            if (!d_req) begin
               next_state = IDLE;
            end else if (ram_ready) begin
               next_state   = DHOLD;
               hold_cnt_nxt = HOLD_ZERO;
               // Only completions that made the icache wait count towards
               // starvation; an uncontended dcache completion clears it.
               if (iREN) begin
                  if (streak != STREAK_MAX) begin
                     streak_nxt = streak + STREAK_ONE;
                  end
               end else begin
                  streak_nxt = STREAK_ZERO;
               end
            end
         end

         IGRANT: begin
            if (!iREN) begin
               next_state = IDLE;
            end else if (ram_ready) begin
               next_state = IDLE;
               streak_nxt = STREAK_ZERO;
            end
         end

         DHOLD: begin
            // The dcache keeps the port across a one-cycle gap between the
            // two words of a block; the starvation limit still overrides.
            if (i_starved) begin
               next_state = IGRANT;
            end else if (d_req) begin
               next_state = DGRANT;
            end else if (hold_cnt == HOLD_LAST) begin
               next_state = IDLE;
            end else if (hold_cnt != HOLD_SAT) begin
               hold_cnt_nxt = hold_cnt + HOLD_ONE;
            end
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   // Outputs are forced to their idle values while RST is high so that an
   // access interrupted by reset cannot produce a completion pulse in the
   // reset cycle itself.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'h0;
      ramstore = 32'h0;
      iwait    = 1'b1;
      dwait    = 1'b1;

      if (!RST) begin
         case (state)
            DGRANT: begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               dwait    = ~(d_req & ram_ready);
            end

            IGRANT: begin
               ramaddr = iaddr;
               ramREN  = iREN;
               iwait   = ~(iREN & ram_ready);
            end

            default: begin
               // IDLE and DHOLD present nothing to the RAM; ram_ready is
               // ignored and both clients keep waiting.
            end
         endcase
      end
   end

   // Read data is broadcast; each client only samples it when its wait is 0.
   assign iload = ramload;
   assign dload = ramload;

endmodule

`default_nettype wire
